// File: rtl/cache_req_ctrl_pkg.sv
// Shared constants for the L1 request controller: line states, bus commands,
// physical address field positions and the controller FSM encoding.
package cache_req_ctrl_pkg;

  typedef enum logic [1:0] {
    LineInvalid     = 2'd0,
    LineSharedClean = 2'd1,
    LineOwnedClean  = 2'd2,
    LineOwnedDirty  = 2'd3
  } line_state_e;

  typedef enum logic [1:0] {
    BusReadShared = 2'd0,
    BusReadOwn    = 2'd1,
    BusWriteback  = 2'd2
  } bus_cmd_e;

  // Physical address split; bits above TagMsb carry no tag information.
  localparam int unsigned OffsetLsb = 0;
  localparam int unsigned OffsetMsb = 1;
  localparam int unsigned IndexLsb  = 2;
  localparam int unsigned IndexMsb  = 11;
  localparam int unsigned TagLsb    = 12;
  localparam int unsigned TagMsb    = 29;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWbReq,
    StWbWait,
    StFillReq,
    StFillWait,
    StUpdate,
    StResp
  } state_e;

endpackage

// File: rtl/cache_perf_cnt.sv
// Saturating event counter: increments on inc and sticks at all-ones.
module cache_perf_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_req_ctrl.sv
// L1 request controller: looks up the tag table, issues writeback/fill bus
// transactions on a miss or upgrade, updates the line and signals completion.
module cache_req_ctrl
  import cache_req_ctrl_pkg::*;
#(
  parameter int unsigned ENTRY_WIDTH    = 10,
  parameter int unsigned ADDR_TAG_WIDTH = 18,
  parameter int unsigned ADDR_P_WIDTH   = 32,
  parameter int unsigned FLAG_WIDTH     = 2,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_P_WIDTH-1:0]   req_addr,
  output logic                      resp_valid,
  output logic                      resp_hit,
  output logic [ENTRY_WIDTH-1:0]    tt_index,
  input  logic                      tt_valid,
  input  logic [FLAG_WIDTH-1:0]     tt_flag,
  input  logic [ADDR_TAG_WIDTH-1:0] tt_addr_tag,
  output logic                      tt_we_flag,
  output logic                      tt_we_addr,
  output logic [FLAG_WIDTH-1:0]     tt_new_flag,
  output logic [ADDR_TAG_WIDTH-1:0] tt_new_addr_tag,
  output logic [ADDR_P_WIDTH-1:0]   tt_new_addr_p,
  output logic                      bus_req,
  output logic [1:0]                bus_cmd,
  output logic [ADDR_P_WIDTH-1:0]   bus_addr,
  input  logic                      bus_gnt,
  input  logic                      bus_done,
  output logic [CNT_WIDTH-1:0]      hit_cnt,
  output logic [CNT_WIDTH-1:0]      miss_cnt
);

  state_e                    state_q, state_d;
  logic                      we_q, we_d;
  logic [ADDR_P_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_TAG_WIDTH-1:0] victim_tag_q, victim_tag_d;
  bus_cmd_e                  fill_cmd_q, fill_cmd_d;
  logic                      wr_hit_own_q, wr_hit_own_d;
  logic                      bus_used_q, bus_used_d;

  logic                      lookup_hit;
  logic                      line_owned;
  logic                      victim_dirty;
  logic [ADDR_P_WIDTH-1:0]   wb_addr;
  logic                      hit_inc;
  logic                      miss_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      victim_tag_q <= '0;
      fill_cmd_q   <= BusReadShared;
      wr_hit_own_q <= 1'b0;
      bus_used_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      victim_tag_q <= victim_tag_d;
      fill_cmd_q   <= fill_cmd_d;
      wr_hit_own_q <= wr_hit_own_d;
      bus_used_q   <= bus_used_d;
    end
  end

  assign lookup_hit   = tt_valid && (tt_addr_tag == addr_q[TagMsb:TagLsb]);
  assign line_owned   = (tt_flag == FLAG_WIDTH'(LineOwnedClean)) ||
                        (tt_flag == FLAG_WIDTH'(LineOwnedDirty));
  assign victim_dirty = tt_valid && (tt_flag == FLAG_WIDTH'(LineOwnedDirty));

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    victim_tag_d = victim_tag_q;
    fill_cmd_d   = fill_cmd_q;
    wr_hit_own_d = wr_hit_own_q;
    bus_used_d   = bus_used_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d                        = req_we;
          // Offset bits are dropped at capture so addr_q is always line aligned.
          addr_d                      = req_addr;
          addr_d[OffsetMsb:OffsetLsb] = '0;
          wr_hit_own_d                = 1'b0;
          bus_used_d                  = 1'b0;
          state_d                     = StLookup;
        end
      end
      StLookup: begin
        victim_tag_d = tt_addr_tag;
        fill_cmd_d   = we_q ? BusReadOwn : BusReadShared;
        if (lookup_hit && !we_q) begin
          state_d = StResp;
        end else if (lookup_hit && line_owned) begin
          wr_hit_own_d = 1'b1;
          state_d      = StUpdate;
        end else if (!lookup_hit && victim_dirty) begin
          bus_used_d = 1'b1;
          state_d    = StWbReq;
        end else begin
          // Plain miss, or write hit on a shared line needing ownership.
          bus_used_d = 1'b1;
          state_d    = StFillReq;
        end
      end
      StWbReq:    if (bus_gnt)  state_d = StWbWait;
      StWbWait:   if (bus_done) state_d = StFillReq;
      StFillReq:  if (bus_gnt)  state_d = StFillWait;
      StFillWait: if (bus_done) state_d = StUpdate;
      StUpdate:   state_d = StResp;
      StResp:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    wb_addr                    = '0;
    wb_addr[TagMsb:TagLsb]     = victim_tag_q;
    wb_addr[IndexMsb:IndexLsb] = addr_q[IndexMsb:IndexLsb];
  end

  assign tt_index = addr_q[IndexMsb:IndexLsb];

  // Every output decodes from registered state only; no bus input feeds bus_req.
  always_comb begin
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_hit        = 1'b0;
    bus_req         = 1'b0;
    bus_cmd         = 2'b00;
    bus_addr        = '0;
    tt_we_flag      = 1'b0;
    tt_we_addr      = 1'b0;
    tt_new_flag     = '0;
    tt_new_addr_tag = '0;
    tt_new_addr_p   = '0;

    case (state_q)
      StIdle: req_ready = 1'b1;
      StWbReq: begin
        bus_req  = 1'b1;
        bus_cmd  = BusWriteback;
        bus_addr = wb_addr;
      end
      StFillReq: begin
        bus_req  = 1'b1;
        bus_cmd  = fill_cmd_q;
        bus_addr = addr_q;
      end
      StUpdate: begin
        tt_we_flag      = 1'b1;
        tt_we_addr      = !wr_hit_own_q;
        tt_new_flag     = we_q ? FLAG_WIDTH'(LineOwnedDirty) : FLAG_WIDTH'(LineSharedClean);
        tt_new_addr_tag = addr_q[TagMsb:TagLsb];
        tt_new_addr_p   = addr_q;
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_hit   = !bus_used_q;
      end
      default: ;
    endcase
  end

  assign hit_inc  = (state_q == StResp) && !bus_used_q;
  assign miss_inc = (state_q == StResp) && bus_used_q;

  cache_perf_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  cache_perf_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_cnt)
  );

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Scoreboard bench for cache_req_ctrl: a tag-table/bus model drives the DUT,
// expectations are queued at issue time and a monitor pops and compares them.
module tb_cache_req_ctrl;

  localparam int unsigned EW = 10;
  localparam int unsigned TW = 18;
  localparam int unsigned AW = 32;
  localparam int unsigned FW = 2;
  // Narrow counters so saturation is reachable in a short run.
  localparam int unsigned CW = 6;
  localparam int unsigned NLines = 1 << EW;
  localparam int CntMax = (1 << CW) - 1;

  logic          clk, rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic          resp_valid, resp_hit;
  logic [EW-1:0] tt_index;
  logic          tt_valid;
  logic [FW-1:0] tt_flag;
  logic [TW-1:0] tt_addr_tag;
  logic          tt_we_flag, tt_we_addr;
  logic [FW-1:0] tt_new_flag;
  logic [TW-1:0] tt_new_addr_tag;
  logic [AW-1:0] tt_new_addr_p;
  logic          bus_req;
  logic [1:0]    bus_cmd;
  logic [AW-1:0] bus_addr;
  logic          bus_gnt, bus_done;
  logic [CW-1:0] hit_cnt, miss_cnt;

  cache_req_ctrl #(
    .CNT_WIDTH (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .resp_valid      (resp_valid),
    .resp_hit        (resp_hit),
    .tt_index        (tt_index),
    .tt_valid        (tt_valid),
    .tt_flag         (tt_flag),
    .tt_addr_tag     (tt_addr_tag),
    .tt_we_flag      (tt_we_flag),
    .tt_we_addr      (tt_we_addr),
    .tt_new_flag     (tt_new_flag),
    .tt_new_addr_tag (tt_new_addr_tag),
    .tt_new_addr_p   (tt_new_addr_p),
    .bus_req         (bus_req),
    .bus_cmd         (bus_cmd),
    .bus_addr        (bus_addr),
    .bus_gnt         (bus_gnt),
    .bus_done        (bus_done),
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag table model, owned by the stimulus process.
  logic          tab_v [NLines];
  logic [1:0]    tab_f [NLines];
  logic [TW-1:0] tab_t [NLines];
  assign tt_valid    = tab_v[tt_index];
  assign tt_flag     = tab_f[tt_index];
  assign tt_addr_tag = tab_t[tt_index];

  typedef struct packed {logic [1:0] cmd; logic [31:0] addr;} bus_exp_t;
  typedef struct packed {logic we_addr; logic [1:0] flag; logic [17:0] tag; logic [31:0] addr_p;} upd_exp_t;
  typedef struct packed {logic hit; logic [3:0] lat;} resp_exp_t;

  bus_exp_t  bus_q [$];
  upd_exp_t  upd_q [$];
  resp_exp_t resp_q [$];

  int checks = 0;
  int errors = 0;
  int n_resp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual 0x%0h required 0x%0h", name, $time, act, exp);
    end
  endtask

  // Bus agent: grants then completes each request after random delays.
  logic bus_auto, agent_gnt, agent_done, man_gnt, man_done;
  assign bus_gnt  = agent_gnt | man_gnt;
  assign bus_done = agent_done | man_done;

  initial begin
    agent_gnt  = 1'b0;
    agent_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_auto && bus_req && !rst) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        agent_gnt = 1'b1;
        @(negedge clk);
        agent_gnt = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        agent_done = 1'b1;
        @(negedge clk);
        agent_done = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents bus, update or response activity.
  initial begin
    int cyc, accept_cyc, mhit, mmiss;
    logic prev_bus, bus_live, cnt_pending, have;
    bus_exp_t cb;
    upd_exp_t ue;
    resp_exp_t re;
    cyc = 0; accept_cyc = 0; mhit = 0; mmiss = 0;
    prev_bus = 1'b0; bus_live = 1'b0; cnt_pending = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mhit = 0; mmiss = 0; prev_bus = 1'b0; cnt_pending = 1'b0;
      end else begin
        if (cnt_pending) begin
          chk("hit_cnt", hit_cnt, mhit);
          chk("miss_cnt", miss_cnt, mmiss);
          cnt_pending = 1'b0;
        end
        if (req_valid && req_ready) accept_cyc = cyc;
        if (bus_req && !prev_bus) begin
          bus_live = bus_q.size() > 0;
          chk("bus_req_expected", bus_live, 1);
          if (bus_live) cb = bus_q.pop_front();
        end
        if (bus_req && bus_live) begin
          chk("bus_cmd", bus_cmd, cb.cmd);
          chk("bus_addr", bus_addr, cb.addr);
        end
        prev_bus = bus_req;
        if (tt_we_flag || tt_we_addr) begin
          have = upd_q.size() > 0;
          chk("update_expected", have, 1);
          if (have) begin
            ue = upd_q.pop_front();
            chk("tt_we_flag", tt_we_flag, 1);
            chk("tt_we_addr", tt_we_addr, ue.we_addr);
            chk("tt_new_flag", tt_new_flag, ue.flag);
            chk("tt_new_addr_tag", tt_new_addr_tag, ue.tag);
            chk("tt_new_addr_p", tt_new_addr_p, ue.addr_p);
          end
        end
        if (resp_valid) begin
          have = resp_q.size() > 0;
          chk("resp_expected", have, 1);
          if (have) begin
            re = resp_q.pop_front();
            chk("resp_hit", resp_hit, re.hit);
            if (re.lat != 0) chk("latency", cyc - accept_cyc, re.lat);
            if (re.hit) mhit = (mhit < CntMax) ? mhit + 1 : CntMax;
            else        mmiss = (mmiss < CntMax) ? mmiss + 1 : CntMax;
            cnt_pending = 1'b1;
          end
          n_resp++;
        end
      end
    end
  end

  task automatic seed(input int idx, input logic v, input logic [1:0] f, input logic [17:0] t);
    tab_v[idx] = v;
    tab_f[idx] = f;
    tab_t[idx] = t;
  endtask

  task automatic send_req(input logic we, input logic [31:0] addr);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
    end
    chk("req_accepted", acc, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
  endtask

  // Reference model: derive the expected transaction from the line's current contents.
  task automatic do_req(input logic we, input logic [31:0] addr);
    int idx, n0;
    logic [17:0] tag;
    logic [31:0] line;
    logic [1:0] f;
    logic hit, upd;
    bit got;
    bus_exp_t b;
    upd_exp_t u;
    resp_exp_t r;
    idx  = int'(addr[11:2]);
    tag  = addr[29:12];
    line = {addr[31:2], 2'b00};
    f    = tab_f[idx];
    hit  = tab_v[idx] && (tab_t[idx] == tag);
    upd  = 1'b0;
    u    = '0;
    if (hit && !we) begin
      r.hit = 1'b1; r.lat = 4'd2;
    end else if (hit && we && (f == 2'd2 || f == 2'd3)) begin
      u.we_addr = 1'b0; u.flag = 2'd3; u.tag = tag; u.addr_p = line;
      upd = 1'b1; r.hit = 1'b1; r.lat = 4'd3;
    end else begin
      if (!hit && tab_v[idx] && f == 2'd3) begin
        b.cmd = 2'd2; b.addr = {2'b00, tab_t[idx], addr[11:2], 2'b00};
        bus_q.push_back(b);
      end
      b.cmd = we ? 2'd1 : 2'd0; b.addr = line;
      bus_q.push_back(b);
      u.we_addr = 1'b1; u.flag = we ? 2'd3 : 2'd1; u.tag = tag; u.addr_p = line;
      upd = 1'b1; r.hit = 1'b0; r.lat = 4'd0;
    end
    if (upd) upd_q.push_back(u);
    resp_q.push_back(r);
    n0 = n_resp;
    send_req(we, addr);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk); #1;
      if (n_resp != n0) got = 1'b1;
    end
    chk("resp_arrived", got, 1);
    if (upd) seed(idx, 1'b1, u.flag, tag);
  endtask

  initial begin
    int idx, n0;
    logic [17:0] tag, other;
    logic [31:0] addr;
    bit seen;
    for (int i = 0; i < NLines; i++) seed(i, 1'b0, 2'd0, '0);
    bus_auto = 1'b1; man_gnt = 1'b0; man_done = 1'b0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_tt_we", {tt_we_flag, tt_we_addr}, 0);
    chk("rst_tt_index", tt_index, 0);
    chk("rst_counters", {hit_cnt, miss_cnt}, 0);

    // Directed: read hit, write hit on dirty line, read miss, dirty-victim write miss.
    seed(0, 1'b1, 2'd3, 18'h2CC);
    do_req(1'b0, 32'h002CC000);
    do_req(1'b1, 32'h002CC000);
    @(negedge clk);
    chk("hit_cnt_two_hits", hit_cnt, 2);
    seed(1, 1'b0, 2'd0, '0);
    do_req(1'b0, 32'h00001004);
    seed(0, 1'b1, 2'd3, 18'h2CC);
    do_req(1'b1, 32'h00ABC000);

    // Reset in FILL_WAIT abandons the request.
    bus_auto = 1'b0;
    bus_q.push_back('{cmd: 2'd0, addr: 32'h00002008});
    send_req(1'b0, 32'h00002008);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk); #1;
      if (bus_req) seen = 1'b1;
    end
    chk("abort_fill_req_seen", seen, 1);
    man_gnt = 1'b1;
    @(negedge clk); #1;
    man_gnt = 1'b0;
    chk("abort_in_fill_wait", bus_req, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_bus_req", bus_req, 0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_tt_we", {tt_we_flag, tt_we_addr}, 0);
    chk("abort_counters", {hit_cnt, miss_cnt}, 0);
    n0 = n_resp;
    #1 man_done = 1'b1;
    @(negedge clk); #1;
    man_done = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_resp", n_resp - n0, 0);
    bus_auto = 1'b1;

    // Random traffic over a few lines so that entries get reused.
    for (int i = 0; i < 150; i++) begin
      idx = $urandom_range(0, 7);
      case ($urandom_range(0, 3))
        0: tag = 18'h2CC;
        1: tag = 18'h001;
        2: tag = 18'h0AB;
        default: tag = 18'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        other = ($urandom_range(0, 1) == 1) ? tag : 18'($urandom);
        seed(idx, 1'($urandom), 2'($urandom), other);
      end
      addr = {2'($urandom), tag, 10'(idx), 2'($urandom)};
      do_req(1'($urandom), addr);
    end

    // Drive misses until the miss counter must sit at all-ones.
    for (int i = 0; i < 70; i++) begin
      seed(5, 1'b0, 2'd0, '0);
      do_req(1'b0, {14'($urandom), 10'd5, 8'h00} | 32'h00000014);
    end
    @(negedge clk);
    chk("miss_cnt_saturated", miss_cnt, CntMax);

    repeat (5) @(negedge clk);
    chk("queues_drained", bus_q.size() + upd_q.size() + resp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
